aes_key_schedule_ctrl: RTL
==========================

// Module: aes_key_schedule_ctrl
// PURPOSE
//  Sequences AES-128 key expansion. Drives one keyOperations instance (RotWord, SubWord, Rcon on a
//  32-bit word) round by round and emits the 11 round keys (round 0..10) in order on a valid/ready
//  stream. Sits between the key load interface and the round datapath / round-key store.
// PARAMETERS
//  ROUNDS  10  last round index emitted; fixed at 10 for AES-128, and other values are unsupported
//  G_PIPE  0   0: g-function combinational, one key per cycle; 1: register g output, one extra cycle per round
// PORTS
//  clk       in   1    single clock; everything is on the rising edge
//  rst       in   1    synchronous, active-high reset
//  start     in   1    load key_in and begin expansion; honoured only in IDLE
//  key_in    in   128  cipher key; w0 = key_in[127:96] ... w3 = key_in[31:0]
//  abort     in   1    synchronous cancel; returns to IDLE
//  busy      out  1    high in every state except IDLE
//  rk_valid  out  1    round key on rk_data is valid
//  rk_ready  in   1    consumer accepts the round key; handshake is rk_valid & rk_ready
//  rk_data   out  128  round key {w4r, w4r+1, w4r+2, w4r+3}
//  rk_round  out  4    round index of rk_data, 0..10
//  done      out  1    one-cycle pulse after round 10 is accepted
// BEHAVIOUR
//  - Reset: state IDLE; busy, rk_valid and done = 0; rk_data = 0; rk_round = 0; internal key reg = 0.
//    Reset overrides everything, including mid-expansion: no done pulse and no further keys.
//  - States: IDLE, EMIT, CALC (CALC exists only when G_PIPE=1).
//  - IDLE: if start & !abort, then cur_key <= key_in, round <= 0, go to EMIT. rk_valid rises in the
//    cycle after start, so first-key latency = 1 cycle.
//  - EMIT: rk_valid = 1, rk_data = cur_key, rk_round = round.
//    - rk_data and rk_round stay stable while rk_valid & !rk_ready.
//    - On handshake with round == ROUNDS: go to IDLE. done = 1 for that next cycle; busy = 0 in the same cycle.
//    - On handshake with round < ROUNDS:
//      - G_PIPE=0: cur_key <= next_key, round <= round+1, stay in EMIT.
//      - G_PIPE=1: g_reg <= g(w3), go to CALC.
//  - CALC (G_PIPE=1 only): rk_valid = 0. cur_key <= next_key using g_reg, round <= round+1, go to EMIT.
//  - next_key: keyOperations is driven with inKey = w3 and roundNo = round+1 (range 1..10), giving g.
//      n0 = w0^g, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3; next_key = {n0,n1,n2,n3}.
//    All XORs are 32-bit. The round counter is 4 bits and never exceeds ROUNDS.
//  - Throughput with rk_ready held high: 11 keys in 11 consecutive cycles (G_PIPE=0), or 21 cycles (G_PIPE=1).
//  - start while busy: ignored; key_in is not sampled.
//  - abort in any non-IDLE state: next cycle IDLE, rk_valid = 0, no done pulse.
//    A handshake in the same cycle as abort still counts as accepted by the consumer, but the FSM aborts anyway.
//  - abort & start together in IDLE: abort wins, start is ignored.
//  - start in the cycle done is high: accepted, since the FSM is already in IDLE.
//  - rk_ready is ignored outside EMIT. rk_valid never drops without a handshake except on abort or rst.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle, rk_ready=1, G_PIPE=0
//    -> round 0 = key_in; round 1 = a0fafe1788542cb123a339392a6c7605;
//       round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; 11 consecutive valid cycles, then done pulse.
//  2 Same key, random rk_ready backpressure (about 50%)
//    -> identical 11 keys in order; rk_data/rk_round held stable across stalls; done exactly once.
//  3 G_PIPE=1, same key, rk_ready=1
//    -> same 11 keys; rk_valid alternates high/low; round 10 accepted 21 cycles after start.
//  4 abort asserted while rk_round=4 and valid
//    -> IDLE next cycle, busy=0, no done. A restart with key 000102030405060708090a0b0c0d0e0f
//       gives round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
//  5 start pulsed while busy with a different key_in
//    -> ignored; the original key sequence is unchanged.
//  6 rst asserted mid-expansion (round 6)
//    -> next cycle all outputs 0 and state IDLE; a following start behaves as in scenario 1.

Source files
------------

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-schedule control/stream bundle.
//   start, key_in, abort : expansion control from the key loader
//   busy, done           : expansion status
//   rk_valid, rk_ready,
//   rk_data, rk_round    : round-key stream towards the round datapath / key store
// slave  : the key-schedule controller side
// master : the loader / consumer side
interface aes_key_schedule_ctrl_if;
    logic         start;
    logic [127:0] key_in;
    logic         abort;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;

    modport slave (
        input  start, key_in, abort, rk_ready,
        output busy, rk_valid, rk_data, rk_round, done
    );

    modport master (
        output start, key_in, abort, rk_ready,
        input  busy, rk_valid, rk_data, rk_round, done
    );
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion sequencer.
// keyOperations : g-function on one 32-bit word (RotWord, SubWord, Rcon).
//   inKey   in  32  word w3 of the current round key
//   roundNo in  4   round being produced, 1..10 (selects Rcon)
//   outKey  out 32  g(inKey)
// aes_key_schedule_ctrl : emits round keys 0..ROUNDS on a valid/ready stream.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   kif      : control/stream bundle (slave side), see aes_key_schedule_ctrl_if
//   ROUNDS   : last round index emitted (10 for AES-128)
//   G_PIPE   : 0 = combinational g, one key per cycle; 1 = registered g, extra cycle per round

module keyOperations (
    input  logic [31:0] inKey,
    input  logic [3:0]  roundNo,
    output logic [31:0] outKey
);
    // Forward S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [31:0] rot;
    logic [7:0]  rcon;

    always_comb begin
        rot = {inKey[23:0], inKey[31:24]};
        case (roundNo)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        outKey = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
                 ^ {rcon, 24'h000000};
    end
endmodule

module aes_key_schedule_ctrl #(
    parameter int ROUNDS = 10,
    parameter int G_PIPE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_key_schedule_ctrl_if.slave  kif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        CALC = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS);

    state_t       state;
    logic [127:0] cur_key;
    logic [3:0]   round;
    logic [3:0]   round_inc;
    logic [31:0]  g_comb;
    logic [31:0]  g_reg;
    logic [31:0]  g_sel;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic         busy_r;
    logic         valid_r;
    logic         done_r;

    assign round_inc = round + 4'd1;

    keyOperations u_keyops (
        .inKey   (cur_key[31:0]),
        .roundNo (round_inc),
        .outKey  (g_comb)
    );

    // In CALC the g value captured during the EMIT handshake is used;
    // round has not yet advanced, so it matches the same roundNo.
    assign g_sel    = (G_PIPE != 0) ? g_reg : g_comb;
    assign n0       = cur_key[127:96] ^ g_sel;
    assign n1       = n0 ^ cur_key[95:64];
    assign n2       = n1 ^ cur_key[63:32];
    assign n3       = n2 ^ cur_key[31:0];
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_key <= '0;
            round   <= '0;
            g_reg   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (kif.start && !kif.abort) begin
                        cur_key <= kif.key_in;
                        round   <= '0;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (kif.abort) begin
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end else if (kif.rk_ready) begin
                        if (round == LAST) begin
                            busy_r  <= 1'b0;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= IDLE;
                        end else if (G_PIPE == 0) begin
                            cur_key <= next_key;
                            round   <= round_inc;
                        end else begin
                            g_reg   <= g_comb;
                            valid_r <= 1'b0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kif.abort) begin
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cur_key <= next_key;
                        round   <= round_inc;
                        valid_r <= 1'b1;
                        state   <= EMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.busy     = busy_r;
    assign kif.rk_valid = valid_r;
    assign kif.rk_data  = cur_key;
    assign kif.rk_round = round;
    assign kif.done     = done_r;
endmodule
